// File: rtl/fixed_requant_skid.sv
// fixed_requant_skid: per-lane fixed-point requantiser (round half up, saturate)
// feeding a 2-entry skid buffer with sticky saturation flag and counter.
module fixed_requant_skid #(
    parameter int IN_WIDTH       = 8,
    parameter int IN_FRAC_WIDTH  = 4,
    parameter int OUT_WIDTH      = 8,
    parameter int OUT_FRAC_WIDTH = 2,
    parameter int IN_SIZE        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE],
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out [IN_SIZE],
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 sat_flag,
    output logic [15:0]          sat_count
);
    localparam int SH  = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam int ASH = SH < 0 ? -SH : SH;
    localparam int WW  = (IN_WIDTH + ASH > OUT_WIDTH ? IN_WIDTH + ASH : OUT_WIDTH) + 2;
    localparam logic signed [WW-1:0] HALF = SH > 0 ? WW'(1) << (SH > 0 ? SH - 1 : 0) : '0;
    localparam logic signed [WW-1:0] MAXV = WW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [WW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t               state_q, state_d;
    logic [OUT_WIDTH-1:0] head_q [IN_SIZE];
    logic [OUT_WIDTH-1:0] head_d [IN_SIZE];
    logic [OUT_WIDTH-1:0] tail_q [IN_SIZE];
    logic [OUT_WIDTH-1:0] tail_d [IN_SIZE];
    logic [OUT_WIDTH-1:0] rq [IN_SIZE];
    logic [IN_SIZE-1:0]   lane_sat;
    logic                 in_ready_q, sat_flag_q;
    logic [15:0]          sat_count_q;
    logic                 accept, drain;

    genvar i;
    for (i = 0; i < IN_SIZE; i++) begin : g_lane
        logic signed [WW-1:0] ext, sc;
        assign ext = WW'($signed(data_in[i]));
        // WW leaves headroom so the rounding add and the left shift never overflow
        assign sc = SH > 0 ? (ext + HALF) >>> ASH : ext <<< ASH;
        assign lane_sat[i] = sc > MAXV || sc < MINV;
        assign rq[i] = sc > MAXV ? MAXV[OUT_WIDTH-1:0] : sc < MINV ? MINV[OUT_WIDTH-1:0] : sc[OUT_WIDTH-1:0];
    end

    assign accept = data_in_valid && in_ready_q;
    assign drain  = data_out_valid && data_out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: if (accept) begin
                state_d = ONE;
                head_d  = rq;
            end
            ONE: if (accept && drain) head_d = rq;
                else if (accept) begin
                    state_d = FULL;
                    tail_d  = rq;
                end else if (drain) state_d = EMPTY;
            FULL: if (drain) begin
                state_d = ONE;
                head_d  = tail_q;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
            head_q      <= '{default: '0};
            tail_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != FULL;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (accept && |lane_sat) begin
                sat_flag_q <= 1'b1;
                if (sat_count_q != 16'hFFFF) sat_count_q <= sat_count_q + 16'd1;
            end
        end
    end

    assign data_in_ready  = in_ready_q;
    assign data_out_valid = state_q != EMPTY;
    assign data_out       = head_q;
    assign sat_flag       = sat_flag_q;
    assign sat_count      = sat_count_q;
endmodule

// File: tb/tb_fixed_requant_skid.sv
// tb_fixed_requant_skid: two instances (8-bit and 4-bit outputs) share stimulus;
// a queue-based arithmetic model predicts handshakes, data and saturation counters.
module tb_fixed_requant_skid;
    localparam int IFW = 4;
    localparam int N   = 4;

    logic       clk = 0, rst = 1;
    logic [7:0] din [N];
    logic       in_valid = 0, out_ready = 0;
    logic       in_ready0, in_ready1, out_valid0, out_valid1, sf0, sf1;
    logic [7:0] dout0 [N];
    logic [3:0] dout1 [N];
    logic [15:0] sc0, sc1;

    always #5 clk = ~clk;

    fixed_requant_skid u0 (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(in_valid), .data_in_ready(in_ready0),
        .data_out(dout0), .data_out_valid(out_valid0), .data_out_ready(out_ready),
        .sat_flag(sf0), .sat_count(sc0)
    );

    fixed_requant_skid #(.OUT_WIDTH(4), .OUT_FRAC_WIDTH(2)) u1 (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(in_valid), .data_in_ready(in_ready1),
        .data_out(dout1), .data_out_valid(out_valid1), .data_out_ready(out_ready),
        .sat_flag(sf1), .sat_count(sc1)
    );

    int          errors = 0, checks = 0, drains = 0;
    int          cnt0 = 0, cnt1 = 0;
    bit          flag0 = 0, flag1 = 0, mon_on = 0, drn, acc;
    logic [31:0] q [$];
    logic [31:0] nb;

    function automatic int raw(int x, int ofw);
        int sh = IFW - ofw;
        if (sh > 0) return int'($floor(real'(x) / (2.0 ** sh) + 0.5));
        return x * (1 << (-sh));
    endfunction

    function automatic int clamp(int r, int ow);
        int hi = (1 << (ow - 1)) - 1;
        int lo = -(1 << (ow - 1));
        return r > hi ? hi : r < lo ? lo : r;
    endfunction

    function automatic int lane(logic [31:0] b, int i);
        return int'($signed(b[i*8 +: 8]));
    endfunction

    function automatic int expq(logic [31:0] b, int i, int ow);
        return clamp(raw(lane(b, i), 2), ow) & ((1 << ow) - 1);
    endfunction

    function automatic bit any_sat(logic [31:0] b, int ow);
        bit s = 0;
        for (int i = 0; i < N; i++) s |= raw(lane(b, i), 2) != clamp(raw(lane(b, i), 2), ow);
        return s;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // compare current outputs against the model, then advance the model past the coming edge
    always @(negedge clk) begin
        if (mon_on) begin
            chk("in_ready0", in_ready0, q.size() < 2);
            chk("in_ready1", in_ready1, q.size() < 2);
            chk("out_valid0", out_valid0, q.size() != 0);
            chk("out_valid1", out_valid1, q.size() != 0);
            if (q.size() != 0)
                for (int i = 0; i < N; i++) begin
                    chk("data0", dout0[i], expq(q[0], i, 8));
                    chk("data1", dout1[i], expq(q[0], i, 4));
                end
            chk("sat_count0", sc0, cnt0);
            chk("sat_count1", sc1, cnt1);
            chk("sat_flag0", sf0, flag0);
            chk("sat_flag1", sf1, flag1);
        end
        if (rst) begin
            q.delete();
            cnt0 = 0; cnt1 = 0; flag0 = 0; flag1 = 0;
        end else begin
            drn = q.size() != 0 && out_ready;
            acc = in_valid && q.size() < 2;
            if (drn) begin
                void'(q.pop_front());
                drains++;
            end
            if (acc) begin
                nb = {din[3], din[2], din[1], din[0]};
                q.push_back(nb);
                if (any_sat(nb, 8)) begin flag0 = 1; if (cnt0 < 65535) cnt0++; end
                if (any_sat(nb, 4)) begin flag1 = 1; if (cnt1 < 65535) cnt1++; end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setb(logic [31:0] b);
        for (int i = 0; i < N; i++) din[i] = b[i*8 +: 8];
    endtask

    task automatic send(logic [31:0] b);
        bit ok = 0;
        setb(b);
        in_valid = 1;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = in_ready0;
            cyc();
        end
        in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    function automatic logic [31:0] rnd_beat(bit heavy);
        logic [31:0] b;
        for (int i = 0; i < N; i++)
            b[i*8 +: 8] = heavy && $urandom_range(0, 1) ? ($urandom_range(0, 1) ? 8'h7F : 8'h80) : 8'($urandom);
        return b;
    endfunction

    initial begin
        int d0, low;
        logic [31:0] a;
        setb('0);
        repeat (3) cyc();
        rst = 0;
        mon_on = 1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_data", dout0[0], 0);
        chk("rst_sat_count", sc1, 0);
        // saturating lanes on the 4-bit instance
        out_ready = 1;
        setb(32'h0000_807F);
        in_valid = 1;
        cyc();
        chk("sat_lane0", dout1[0], 4'h7);
        chk("sat_lane1", dout1[1], 4'h8);
        chk("sat_flag", sf1, 1);
        chk("sat_count", sc1, 1);
        // rounding on the 8-bit instance
        setb(32'h00FD_F613);
        cyc();
        in_valid = 0;
        chk("rnd_lane0", dout0[0], 8'h05);
        chk("rnd_lane1", dout0[1], 8'hFE);
        chk("rnd_lane2", dout0[2], 8'hFF);
        chk("rnd_lane3", dout0[3], 8'h00);
        chk("rnd_sat_flag", sf0, 0);
        repeat (2) cyc();
        // backpressure: two beats fill the buffer, third waits
        out_ready = 0;
        a = rnd_beat(0);
        send(a);
        send(rnd_beat(0));
        chk("bp_in_ready", in_ready0, 0);
        chk("bp_head", dout0[2], expq(a, 2, 8));
        repeat (3) cyc();
        chk("bp_hold", in_ready0, 0);
        out_ready = 1;
        send(rnd_beat(0));
        repeat (3) cyc();
        // sustained throughput
        d0 = drains;
        low = 0;
        for (int k = 0; k < 100; k++) begin
            setb(rnd_beat(0));
            in_valid = 1;
            if (!in_ready0) low++;
            cyc();
        end
        in_valid = 0;
        cyc();
        chk("thru_drains", drains - d0, 100);
        chk("thru_in_ready_low", low, 0);
        // reset while full
        out_ready = 0;
        send(rnd_beat(1));
        send(rnd_beat(1));
        u1.sat_count_q = 16'd5;
        cnt1 = 5;
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("rst_full_out_valid", out_valid0, 0);
        chk("rst_full_in_ready", in_ready0, 1);
        chk("rst_full_sat_count", sc1, 0);
        chk("rst_full_data", dout0[0], 0);
        // randomised traffic
        for (int k = 0; k < 3000; k++) begin
            setb(rnd_beat(k[0]));
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            cyc();
        end
        u1.sat_count_q = 16'hFFFD;
        cnt1 = 65533;
        for (int k = 0; k < 500; k++) begin
            setb(rnd_beat(1));
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            cyc();
        end
        in_valid = 0;
        out_ready = 1;
        repeat (3) cyc();
        chk("sat_count_top", sc1, 16'hFFFF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
